cskipa_sum_accumulator: RTL and testbench
=========================================

Name: cskipa_sum_accumulator

Overview:
- Downstream consumer of the 12-bit carry-skip adder stage.
- Takes each adder result ({cout, sum}) over a valid/ready handshake and accumulates it into a wider register.
- Presents a block total after COUNT samples, or earlier on flush, with a sticky overflow flag.
- Feeds the block-level result bus.

Parameters:
- WIDTH, 12: adder sum width; input value is WIDTH+1 bits {i_cout, i_sum}.
- ACC_WIDTH, 16: accumulator width; must be >= WIDTH+1.
- COUNT, 8: samples per block; must be >= 1.
- CNT_W, 4: sample-counter width; must hold the value COUNT.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_valid  in  1  upstream result valid.
- o_ready  out  1  accumulator accepts a sample.
- i_sum  in  WIDTH  adder sum.
- i_cout  in  1  adder carry-out.
- i_flush  in  1  close current block early.
- o_valid  out  1  block total valid.
- i_ready  in  1  downstream accepts total.
- o_acc  out  ACC_WIDTH  running sum; final block total while o_valid=1.
- o_count  out  CNT_W  samples in current/presented block.
- o_overflow  out  1  sticky: block sum exceeded ACC_WIDTH.

Behaviour:
- Reset (i_rst_n=0 at edge):
  - state=ACCUM; o_acc=0, o_count=0, o_overflow=0, o_valid=0.
  - o_ready=0 while i_rst_n is low; otherwise o_ready = (state==ACCUM).
  - Reset mid-block or during HOLD discards everything; no output handshake occurs.
- Sample value v = zero-extend({i_cout, i_sum}) to ACC_WIDTH+1 bits.
- Accept = i_valid & o_ready.
- ACCUM state, on accept:
  - acc <= (acc + v) mod 2^ACC_WIDTH.
  - o_overflow <= o_overflow | carry out of bit ACC_WIDTH-1.
  - o_count <= o_count + 1.
  - If o_count==COUNT-1: go to HOLD; o_valid=1 the next cycle. Latency is 1 cycle from the final accept to o_valid.
- Flush in ACCUM:
  - If i_flush=1 and (accept or o_count>0): go to HOLD after applying any same-cycle sample.
  - Simultaneous flush + accept includes that sample in the block.
  - Flush with o_count=0 and no accept is ignored.
- HOLD state:
  - o_ready=0, o_valid=1; o_acc, o_count and o_overflow are stable.
  - i_flush is ignored; i_valid is back-pressured and the upstream holds its data.
  - On i_ready=1: acc, count and overflow clear to 0; return to ACCUM with o_ready=1 the next cycle.
  - Minimum one bubble cycle between blocks.
- o_valid never drops without i_ready.
- o_count never exceeds COUNT.
- The default parameters cannot overflow (8 × 0x1FFF = 0xFFF8). Overflow applies only for smaller ACC_WIDTH or larger COUNT.
- All outputs are registered except o_ready, which is decoded from state and i_rst_n.

Optional Feature:
- Macro: CSKIPA_ACC_SATURATE_EN.
- Defined: on overflow, acc <= all-ones (2^ACC_WIDTH - 1) and stays saturated for the rest of the block. o_overflow is set as normal.
- Undefined: acc wraps modulo 2^ACC_WIDTH; o_overflow is set as normal.

Test Plan:
- Full block, no stalls: 8 accepts of i_sum=0xFFF, i_cout=1 with i_ready=1 -> one cycle after 8th accept, o_valid=1, o_acc=0xFFF8, o_count=8, o_overflow=0; then o_ready=1 with o_acc=0.
- Downstream backpressure: 8 samples of 0x001, i_ready=0 for 5 cycles -> o_valid=1, o_acc=0x0008 stable and o_ready=0 throughout; release i_ready -> next cycle o_valid=0, o_ready=1.
- Early flush with sample: 2 samples of 0x010, then 3rd sample 0x020 with i_flush=1 in the same cycle -> o_acc=0x0040, o_count=3; flush with o_count=0 and i_valid=0 -> no o_valid.
- Wrap/overflow with ACC_WIDTH=14: 3 samples of {1, 0xFFF}=0x1FFF -> o_acc=0x1FFD, o_overflow=1. With CSKIPA_ACC_SATURATE_EN defined -> o_acc=0x3FFF, o_overflow=1.
- Reset mid-operation: 5 samples accepted, then i_rst_n=0 for 1 cycle -> o_acc=0, o_count=0, o_overflow=0, o_valid=0, o_ready=0 during reset, o_ready=1 after.
- Random valid/ready throttling over 100 blocks -> each total matches the reference model sum of accepted samples; no sample lost or duplicated.

Source files
------------

// File: rtl/cskipa_sum_accumulator.sv
// Accumulates {cout, sum} results from the carry-skip adder into blocks of COUNT samples.
// Optional macro CSKIPA_ACC_SATURATE_EN: clamp the accumulator at all-ones on overflow instead of wrapping.
module cskipa_sum_accumulator #(
  parameter int WIDTH     = 12,
  parameter int ACC_WIDTH = 16,
  parameter int COUNT     = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_sum,
  input  logic                 i_cout,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_overflow
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;

  logic [ACC_WIDTH:0]   sample_ext;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH-1:0] add_acc;
  logic                 add_carry;
  logic                 accept;
  logic                 close_block;

  assign o_ready    = i_rst_n & (state_q == ST_ACCUM);
  assign accept     = i_valid & o_ready;
  assign o_valid    = valid_q;
  assign o_acc      = acc_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

  // One extra bit on the adder exposes the carry out of the accumulator's MSB.
  assign sample_ext = {{(ACC_WIDTH - WIDTH){1'b0}}, i_cout, i_sum};
  assign sum_ext    = {1'b0, acc_q} + sample_ext;
  assign add_carry  = sum_ext[ACC_WIDTH];

`ifdef CSKIPA_ACC_SATURATE_EN
  // Once at all-ones, any non-zero add carries again, so the clamp holds for the block.
  assign add_acc = add_carry ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
`else
  assign add_acc = sum_ext[ACC_WIDTH-1:0];
`endif

  // A flush with nothing accepted and nothing this cycle is a no-op.
  assign close_block = (accept && (count_q == LAST_CNT)) ||
                       (i_flush && (accept || (count_q != '0)));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          acc_d   = add_acc;
          ovf_d   = ovf_q | add_carry;
          count_d = count_q + CNT_W'(1);
        end
        if (close_block) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_cskipa_sum_accumulator.sv
// Scoreboard bench: a 16-bit and a 14-bit accumulator share one stimulus stream.
// The driver queues expected block totals; a negedge monitor pops and compares them.
module tb_cskipa_sum_accumulator;

`ifdef CSKIPA_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n, i_valid, i_cout, i_flush, i_ready;
  logic [11:0] i_sum;
  logic        o_ready_a, o_valid_a, o_ovf_a;
  logic [15:0] o_acc_a;
  logic [3:0]  o_cnt_a;
  logic        o_ready_b, o_valid_b, o_ovf_b;
  logic [13:0] o_acc_b;
  logic [3:0]  o_cnt_b;

  always #5 clk = ~clk;

  cskipa_sum_accumulator dut_a (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_a),
    .i_sum(i_sum), .i_cout(i_cout), .i_flush(i_flush), .o_valid(o_valid_a),
    .i_ready(i_ready), .o_acc(o_acc_a), .o_count(o_cnt_a), .o_overflow(o_ovf_a)
  );

  cskipa_sum_accumulator #(.ACC_WIDTH(14)) dut_b (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_sum(i_sum), .i_cout(i_cout), .i_flush(i_flush), .o_valid(o_valid_b),
    .i_ready(i_ready), .o_acc(o_acc_b), .o_count(o_cnt_b), .o_overflow(o_ovf_b)
  );

  typedef struct {
    logic [15:0] a16;
    logic        o16;
    logic [13:0] a14;
    logic        o14;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   txn = 0;

  // Reference model (used to generate expectations during the random phase)
  int   m16, m14, mcnt;
  bit   mo16, mo14;
  bit   use_model = 1'b0;
  bit   last_acc;
  int   n_blocks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] a16, input logic o16,
                          input logic [13:0] a14, input logic o14, input logic [3:0] cnt);
    exp_t e;
    e.a16 = a16; e.o16 = o16; e.a14 = a14; e.o14 = o14; e.cnt = cnt;
    q.push_back(e);
  endtask

  // Apply inputs at posedge+1, update the model from o_ready, advance to next posedge+1.
  task automatic drive(input logic v, input logic [12:0] d, input logic fl, input logic rdy);
    int s;
    i_valid = v; i_cout = d[12]; i_sum = d[11:0]; i_flush = fl; i_ready = rdy;
    #1;
    last_acc = i_valid && o_ready_a;
    if (!i_rst_n) begin
      m16 = 0; m14 = 0; mo16 = 0; mo14 = 0; mcnt = 0;
    end else if (o_ready_a) begin
      if (last_acc) begin
        s = m16 + int'(d);
        if (s > 65535) begin mo16 = 1; m16 = SAT ? 65535 : s - 65536; end else m16 = s;
        s = m14 + int'(d);
        if (s > 16383) begin mo14 = 1; m14 = SAT ? 16383 : s - 16384; end else m14 = s;
        mcnt++;
      end
      if ((last_acc && mcnt == 8) || (fl && mcnt != 0)) begin
        if (use_model) begin
          push_exp(16'(m16), mo16, 14'(m14), mo14, 4'(mcnt));
          n_blocks++;
        end
        m16 = 0; m14 = 0; mo16 = 0; mo14 = 0; mcnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one expectation per presented block, recheck it every HOLD cycle.
  exp_t cur;
  bit   holding = 1'b0;
  bit   have_cur = 1'b0;
  always @(negedge clk) begin
    if (o_valid_a === 1'b1) begin
      if (!holding) begin
        holding = 1'b1;
        if (q.size() == 0) begin
          have_cur = 1'b0;
          compared++; mismatched++;
          $display("FAIL unexpected_block: got o_valid=1 expected no block at %0t", $time);
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          txn++;
          $display("block %0d: acc16=0x%0h cnt=%0d ovf16=%0b acc14=0x%0h ovf14=%0b",
                   txn, o_acc_a, o_cnt_a, o_ovf_a, o_acc_b, o_ovf_b);
        end
      end
      if (have_cur) begin
        chk("acc16", 32'(o_acc_a), 32'(cur.a16));
        chk("cnt16", 32'(o_cnt_a), 32'(cur.cnt));
        chk("ovf16", 32'(o_ovf_a), 32'(cur.o16));
        chk("acc14", 32'(o_acc_b), 32'(cur.a14));
        chk("ovf14", 32'(o_ovf_b), 32'(cur.o14));
        chk("valid14", 32'(o_valid_b), 32'd1);
        chk("ready_in_hold", 32'(o_ready_a), 32'd0);
      end
    end else begin
      holding = 1'b0;
      have_cur = 1'b0;
    end
  end

  initial begin
    bit         hold_pend;
    logic       rv, rf, rr;
    logic [12:0] rd;
    int         cyc;

    i_rst_n = 1'b0; i_valid = 0; i_cout = 0; i_sum = '0; i_flush = 0; i_ready = 0;
    @(posedge clk); #1;
    drive(0, 13'h0, 0, 0);
    drive(0, 13'h0, 0, 0);
    chk("rst_ready", 32'(o_ready_a), 32'd0);
    chk("rst_acc", 32'(o_acc_a), 32'd0);
    chk("rst_cnt", 32'(o_cnt_a), 32'd0);
    chk("rst_ovf", 32'(o_ovf_a), 32'd0);
    chk("rst_valid", 32'(o_valid_a), 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(o_ready_a), 32'd1);

    // Full block of 0x1FFF: 16-bit sum 0xFFF8; 14-bit wraps to 0x3FF8 (or clamps to 0x3FFF)
    push_exp(16'hFFF8, 1'b0, SAT ? 14'h3FFF : 14'h3FF8, 1'b1, 4'd8);
    for (int i = 0; i < 8; i++) drive(1, 13'h1FFF, 0, 1);
    chk("full_latency_valid", 32'(o_valid_a), 32'd1);
    drive(0, 13'h0, 0, 1);
    chk("full_after_valid", 32'(o_valid_a), 32'd0);
    chk("full_after_ready", 32'(o_ready_a), 32'd1);
    chk("full_after_acc", 32'(o_acc_a), 32'd0);

    // Backpressure: 8 x 1, downstream stalls 5 cycles
    push_exp(16'h0008, 1'b0, 14'h0008, 1'b0, 4'd8);
    for (int i = 0; i < 8; i++) drive(1, 13'h0001, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 13'h0001, 0, 0);
      chk("bp_ready", 32'(o_ready_a), 32'd0);
      chk("bp_valid", 32'(o_valid_a), 32'd1);
    end
    drive(0, 13'h0, 0, 1);
    chk("bp_release_valid", 32'(o_valid_a), 32'd0);
    chk("bp_release_ready", 32'(o_ready_a), 32'd1);

    // Early flush with same-cycle sample: 0x10 + 0x10 + 0x20
    push_exp(16'h0040, 1'b0, 14'h0040, 1'b0, 4'd3);
    drive(1, 13'h0010, 0, 1);
    drive(1, 13'h0010, 0, 1);
    drive(1, 13'h0020, 1, 1);
    drive(0, 13'h0, 0, 1);
    drive(0, 13'h0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 13'h0, 0, 1);
      chk("empty_flush_no_valid", 32'(o_valid_a), 32'd0);
    end

    // 3 x 0x1FFF flushed: 0x5FFD fits 16 bits; 14 bits wrap to 0x1FFD or clamp to 0x3FFF
    push_exp(16'h5FFD, 1'b0, SAT ? 14'h3FFF : 14'h1FFD, 1'b1, 4'd3);
    drive(1, 13'h1FFF, 0, 1);
    drive(1, 13'h1FFF, 0, 1);
    drive(1, 13'h1FFF, 1, 1);
    drive(0, 13'h0, 0, 1);

    // Reset after 5 accepted samples: block discarded
    for (int i = 0; i < 5; i++) drive(1, 13'h0005, 0, 1);
    chk("mid_cnt_before_rst", 32'(o_cnt_a), 32'd5);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(o_ready_a), 32'd0);
    drive(1, 13'h0005, 0, 1);
    chk("mid_rst_acc", 32'(o_acc_a), 32'd0);
    chk("mid_rst_cnt", 32'(o_cnt_a), 32'd0);
    chk("mid_rst_ovf", 32'(o_ovf_b), 32'd0);
    chk("mid_rst_valid", 32'(o_valid_a), 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("mid_rst_ready_after", 32'(o_ready_a), 32'd1);

    // Random throttling, 100 blocks, expectations from the model
    use_model = 1'b1;
    hold_pend = 1'b0;
    rd = '0; rv = 0;
    cyc = 0;
    while (n_blocks < 100 && cyc < 20000) begin
      if (!hold_pend) begin
        rv = ($urandom_range(3) != 0);
        rd = 13'($urandom_range(8191));
      end
      rf = ($urandom_range(15) == 0);
      rr = ($urandom_range(2) != 0);
      drive(rv, rd, rf, rr);
      hold_pend = rv && !last_acc;
      cyc++;
    end
    if (n_blocks < 100) begin
      compared++; mismatched++;
      $display("FAIL random_blocks_timeout: got %0d blocks expected 100", n_blocks);
    end

    cyc = 0;
    while ((q.size() != 0 || o_valid_a) && cyc < 100) begin
      drive(0, 13'h0, 0, 1);
      cyc++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    chk("drain_valid_low", 32'(o_valid_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
